systolic_pe_array: RTL and testbench

//  Weight-stationary NxN grid of multiply-accumulate PEs, directly downstream of SystolicController.
//  - Consumes the controller's pre-skewed activations (data_in) and the weight matrix (weight_in).
//  - Returns one column-sum per column (result_col) with per-column valid flags.
//  - Activations move right one PE per cycle; partial sums move down one PE per cycle.

---
 rtl/systolic_pe_array.sv | 176 +++++++++++++++++
 tb/tb_systolic_pe_array.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_array.sv
// -----------------------------------------------------------------------------
// systolic_pe_array
//
// Weight-stationary N x N grid of multiply-accumulate processing elements.
// The upstream controller supplies activations that are already skewed: row r
// arrives r cycles after row 0. Activations move one PE to the right on every
// clock, and partial sums move one PE down on every clock. Each column's sum
// leaves through the bottom row.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   weight_load   pulse: capture weight_in into every PE (only while idle)
//   weight_in     N*N signed weights, element (r*N+c) -> PE[r][c]
//   data_in       N signed activations, element r -> row r
//   data_valid    per-row activation valid, travels with the data
//   result_col    N signed column sums; each holds its value while its valid is low
//   result_valid  per-column result valid
//   busy          at least one activation or psum valid is in flight
//   weight_rej    sticky: a weight_load was dropped because busy was set
//
// Configuration
//   SYSTOLIC_SATURATE_EN : defined   -> each PE clamps its sum to the signed
//                                       WIDTH range
//                          undefined -> each PE keeps the low WIDTH bits
//                                       (two's-complement wrap)
// -----------------------------------------------------------------------------
module systolic_pe_array #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   weight_load,
    input  logic [N*N*WIDTH-1:0]   weight_in,
    input  logic [N*WIDTH-1:0]     data_in,
    input  logic [N-1:0]           data_valid,
    output logic [N*WIDTH-1:0]     result_col,
    output logic [N-1:0]           result_valid,
    output logic                   busy,
    output logic                   weight_rej
);

`ifdef SYSTOLIC_SATURATE_EN
    // The sum width holds a full product plus one psum without overflowing.
    localparam int SW = 2*WIDTH + 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] sat_clamp(input logic signed [SW-1:0] s);
        logic signed [WIDTH-1:0] res;
        if (s > SAT_MAX) begin
            res = WIDTH'(SAT_MAX);
        end else if (s < SAT_MIN) begin
            res = WIDTH'(SAT_MIN);
        end else begin
            res = s[WIDTH-1:0];
        end
        return res;
    endfunction
`endif

    // PE state
    logic signed [WIDTH-1:0] w_r    [N][N];
    logic signed [WIDTH-1:0] a_r    [N][N];
    logic                    av_r   [N][N];
    logic signed [WIDTH-1:0] ps_r   [N][N];
    logic                    psv_r  [N][N];
    logic                    busy_r;
    logic                    weight_rej_r;

    // Routing and next-state values
    logic signed [WIDTH-1:0] a_in_s   [N][N];
    logic                    av_in_s  [N][N];
    logic signed [WIDTH-1:0] ps_in_s  [N][N];
    logic                    psv_in_s [N][N];
    logic signed [WIDTH-1:0] ps_nxt_s [N][N];
    logic                    psv_nxt_s[N][N];
    logic                    busy_nxt_s;
    logic                    weight_accept_s;

    assign weight_accept_s = weight_load & ~busy_r;

    // Neighbour routing: activations enter from the left, psums from above.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_in_s[r][0]  = data_in[r*WIDTH +: WIDTH];
            av_in_s[r][0] = data_valid[r];
            for (int c = 1; c < N; c++) begin
                a_in_s[r][c]  = a_r[r][c-1];
                av_in_s[r][c] = av_r[r][c-1];
            end
        end
        for (int c = 0; c < N; c++) begin
            ps_in_s[0][c]  = '0;
            psv_in_s[0][c] = 1'b0;
            for (int r = 1; r < N; r++) begin
                ps_in_s[r][c]  = ps_r[r-1][c];
                psv_in_s[r][c] = psv_r[r-1][c];
            end
        end
    end

    // Per-PE multiply-accumulate. An invalid activation passes the upstream
    // psum through unchanged. The psum stays valid while either input is valid,
    // so a row driven with data_valid=0 adds nothing but keeps the column going.
    always_comb begin
        busy_nxt_s = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (av_r[r][c]) begin
`ifdef SYSTOLIC_SATURATE_EN
                    ps_nxt_s[r][c] = sat_clamp(SW'(ps_in_s[r][c]) +
                                               SW'(a_r[r][c]) * SW'(w_r[r][c]));
`else
                    // The low WIDTH bits of the full sum equal the WIDTH-wide sum.
                    ps_nxt_s[r][c] = ps_in_s[r][c] + a_r[r][c] * w_r[r][c];
`endif
                end else begin
                    ps_nxt_s[r][c] = ps_in_s[r][c];
                end
                psv_nxt_s[r][c] = av_r[r][c] | psv_in_s[r][c];
                busy_nxt_s      = busy_nxt_s | av_in_s[r][c] | psv_nxt_s[r][c];
            end
        end
    end

    // Pipeline registers, weight capture and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_r[r][c]   <= '0;
                    a_r[r][c]   <= '0;
                    av_r[r][c]  <= 1'b0;
                    ps_r[r][c]  <= '0;
                    psv_r[r][c] <= 1'b0;
                end
            end
            busy_r       <= 1'b0;
            weight_rej_r <= 1'b0;
        end else begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (weight_accept_s) begin
                        w_r[r][c] <= weight_in[(r*N+c)*WIDTH +: WIDTH];
                    end
                    a_r[r][c]   <= a_in_s[r][c];
                    av_r[r][c]  <= av_in_s[r][c];
                    psv_r[r][c] <= psv_nxt_s[r][c];
                    // The bottom row is the output register, so it holds
                    // between results. Upper rows always follow the pipeline.
                    if ((r == N-1) && !psv_nxt_s[r][c]) begin
                        ps_r[r][c] <= ps_r[r][c];
                    end else begin
                        ps_r[r][c] <= ps_nxt_s[r][c];
                    end
                end
            end
            busy_r       <= busy_nxt_s;
            weight_rej_r <= weight_rej_r | (weight_load & busy_r);
        end
    end

    // Flatten the bottom-row registers onto the output buses.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            result_col[c*WIDTH +: WIDTH] = ps_r[N-1][c];
            result_valid[c]              = psv_r[N-1][c];
        end
    end

    assign busy       = busy_r;
    assign weight_rej = weight_rej_r;

endmodule

// File: tb/tb_systolic_pe_array.sv
// -----------------------------------------------------------------------------
// tb_systolic_pe_array
//
// Directed self-checking bench for systolic_pe_array with N=4 and WIDTH=16.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at the
// same point, after the edge they depend on.
// -----------------------------------------------------------------------------
module tb_systolic_pe_array;

    localparam int N = 4;
    localparam int W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 weight_load;
    logic [N*N*W-1:0]     weight_in;
    logic [N*W-1:0]       data_in;
    logic [N-1:0]         data_valid;
    logic [N*W-1:0]       result_col;
    logic [N-1:0]         result_valid;
    logic                 busy;
    logic                 weight_rej;

    int n_cmp = 0;
    int n_err = 0;

    // vec[m][r]: activation for row r of vector m.
    // exp_v[m][c]: expected sum for column c of vector m.
    logic signed [W-1:0]  vec   [4][4];
    logic [W-1:0]         exp_v [4][4];
    int                   nvec  = 0;

    systolic_pe_array #(.N(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .weight_load  (weight_load),
        .weight_in    (weight_in),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .result_col   (result_col),
        .result_valid (result_valid),
        .busy         (busy),
        .weight_rej   (weight_rej)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*N*W-1:0] w_all(input logic [W-1:0] v);
        logic [N*N*W-1:0] w;
        for (int i = 0; i < N*N; i++) w[i*W +: W] = v;
        return w;
    endfunction

    function automatic logic [N*N*W-1:0] w_ident();
        logic [N*N*W-1:0] w;
        w = '0;
        for (int r = 0; r < N; r++) w[(r*N+r)*W +: W] = 16'd1;
        return w;
    endfunction

    // Drive the skewed inputs for cycle k: row r carries vector k-r.
    task automatic set_inputs(input int k);
        int m;
        for (int r = 0; r < N; r++) begin
            m = k - r;
            if (m >= 0 && m < nvec) begin
                data_in[r*W +: W] = vec[m][r];
                data_valid[r]     = 1'b1;
            end else begin
                data_in[r*W +: W] = 16'd0;
                data_valid[r]     = 1'b0;
            end
        end
    endtask

    task automatic load_w(input logic [N*N*W-1:0] w);
        weight_in   = w;
        weight_load = 1'b1;
        @(posedge clk); #1;
        weight_load = 1'b0;
    endtask

    // Feed nv back-to-back vectors. Check every column's values and arrival
    // cycles and when busy falls. A weight_load pulse is issued on cycle
    // load_k (skipped when load_k < 0).
    task automatic run_vecs(input int nv, input string tag, input int load_k,
                            input logic [N*N*W-1:0] lw);
        int got [N];
        int k_last;
        int m;
        nvec   = nv;
        k_last = nv + 2*N - 2;
        for (int c = 0; c < N; c++) got[c] = 0;
        for (int k = 0; k < nv + 2*N + 2; k++) begin
            set_inputs(k);
            if (k == load_k) begin
                weight_in   = lw;
                weight_load = 1'b1;
            end else begin
                weight_load = 1'b0;
            end
            @(posedge clk); #1;
            for (int c = 0; c < N; c++) begin
                if (result_valid[c]) begin
                    m = got[c];
                    if (m < nv) begin
                        chk($sformatf("%s_val_c%0d_v%0d", tag, c, m),
                            64'(result_col[c*W +: W]), 64'(exp_v[m][c]));
                        chk($sformatf("%s_cyc_c%0d_v%0d", tag, c, m),
                            64'(k), 64'(m + N + c));
                    end else begin
                        chk($sformatf("%s_extra_c%0d", tag, c), 64'(m + 1), 64'(nv));
                    end
                    got[c] = got[c] + 1;
                end
            end
            if (k == k_last)     chk({tag, "_busy_last"}, 64'(busy), 64'd1);
            if (k == k_last + 1) chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
        end
        weight_load = 1'b0;
        for (int c = 0; c < N; c++)
            chk($sformatf("%s_count_c%0d", tag, c), 64'(got[c]), 64'(nv));
    endtask

    initial begin
        int bad;
        rst         = 1'b0;
        weight_load = 1'b0;
        weight_in   = '0;
        data_in     = '0;
        data_valid  = '0;

        // Reset state
        #12;
        chk("rst_result_col",   64'(result_col),   64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_busy",         64'(busy),         64'd0);
        chk("rst_weight_rej",   64'(weight_rej),   64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Identity weights: column c returns x[c]
        load_w(w_ident());
        vec[0]   = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        exp_v[0] = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_vecs(1, "ident", -1, '0);

        // Uniform weights of 2: a single vector, then four back-to-back vectors
        load_w(w_all(16'd2));
        vec[0]   = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        exp_v[0] = '{16'd20, 16'd20, 16'd20, 16'd20};
        run_vecs(1, "uniform", -1, '0);
        vec[1]   = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        exp_v[1] = '{16'd8, 16'd8, 16'd8, 16'd8};
        vec[2]   = '{-16'sd1, 16'sd0, 16'sd0, 16'sd0};
        exp_v[2] = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
        vec[3]   = '{16'sd0, 16'sd0, 16'sd0, 16'sd5};
        exp_v[3] = '{16'd10, 16'd10, 16'd10, 16'd10};
        run_vecs(4, "b2b", -1, '0);

        // Weight reject: a load of W=0 while busy is dropped; results still use W=2
        run_vecs(1, "reject", 2, w_all(16'd0));
        chk("reject_sticky", 64'(weight_rej), 64'd1);

        // A later load while idle is accepted (W=1 -> 1+2+3+4)
        load_w(w_all(16'd1));
        exp_v[0] = '{16'd10, 16'd10, 16'd10, 16'd10};
        run_vecs(1, "reload", -1, '0);
        chk("reject_still_sticky", 64'(weight_rej), 64'd1);

        // Same-edge load and data while idle: the new W=3 applies, so each column is 12
        vec[0]   = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        exp_v[0] = '{16'd12, 16'd12, 16'd12, 16'd12};
        run_vecs(1, "same_edge", 0, w_all(16'd3));

        // Overflow with maximum positive operands
        load_w(w_all(16'h7FFF));
        vec[0] = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
`ifdef SYSTOLIC_SATURATE_EN
        exp_v[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
`else
        exp_v[0] = '{16'h0004, 16'h0004, 16'h0004, 16'h0004};
`endif
        run_vecs(1, "ovf_pos", -1, '0);
        // Each product is -2^30 + 2^15. Wrap: 4 * 0x8000 keeps 0x0000. Saturate: 0x8000.
        vec[0] = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
`ifdef SYSTOLIC_SATURATE_EN
        exp_v[0] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
`else
        exp_v[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
        run_vecs(1, "ovf_neg", -1, '0);

        // Mid-stream reset: start a vector, then assert reset between edges
        load_w(w_all(16'd1));
        vec[0] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        nvec   = 1;
        for (int k = 0; k < 6; k++) begin
            set_inputs(k);
            @(posedge clk); #1;
        end
        chk("mid_pre_valid_c1", 64'(result_valid[1]), 64'd1);
        chk("mid_pre_col0",     64'(result_col[0 +: W]), 64'd10);
        set_inputs(100);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_result_col",   64'(result_col),   64'd0);
        chk("mid_rst_result_valid", 64'(result_valid), 64'd0);
        chk("mid_rst_busy",         64'(busy),         64'd0);
        chk("mid_rst_weight_rej",   64'(weight_rej),   64'd0);
        @(negedge clk); rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (result_valid !== 4'd0 || busy !== 1'b0) bad = bad + 1;
        end
        chk("post_rst_idle", 64'(bad), 64'd0);

        // Reset also cleared the weights, so new data sums to zero
        vec[0]   = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        exp_v[0] = '{16'd0, 16'd0, 16'd0, 16'd0};
        run_vecs(1, "post_rst_w0", -1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
